// File: rtl/sweep_counter_ctrl_pkg.sv
// Shared types and constants for the sweep counter controller and its counter core.
// The ST_* codes are the values presented on the debug state bus.
package sweep_pkg;

  localparam int W_DEF  = 4;
  localparam int NW_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    UP   = ST_UP,
    DOWN = ST_DOWN,
    DONE = ST_DONE
  } sweep_state_e;

  // Even parity over the debug state code, for consumers that want a protected copy.
  function automatic logic state_parity(input logic [1:0] st);
    return ^st;
  endfunction

endpackage

// File: rtl/sweep_counter_ctrl_core.sv
// W-bit loadable up/down counter. Load has priority over count enable.
module sweep_counter_core
  import sweep_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic         up_down_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: load, step in the requested direction, or hold.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      if (up_down_i) begin
        count_d = count_q + W'(1);
      end else begin
        count_d = count_q - W'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/sweep_counter_ctrl.sv
// Triangular sweep sequencer: runs the counter core lo -> hi -> lo for N sweeps,
// then pulses done. Limits and sweep count are latched when a start is accepted.
module sweep_counter_ctrl
  import sweep_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int NW = NW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          pause_i,
  input  logic [W-1:0]  lo_lim_i,
  input  logic [W-1:0]  hi_lim_i,
  input  logic [NW-1:0] n_sweeps_i,
  output logic [W-1:0]  count_o,
  output logic          up_down_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [NW-1:0] sweeps_done_o,
  output logic [1:0]    dbg_state_o
);

  sweep_state_e  state_q;
  logic [W-1:0]  lo_q;
  logic [W-1:0]  hi_q;
  logic [NW-1:0] n_q;
  logic [NW-1:0] sweeps_done_q;
  logic          up_down_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic [W-1:0]  count_s;
  logic          start_req_s;
  logic          lim_bad_s;
  logic          run_s;
  logic          at_hi_s;
  logic          at_lo_s;
  logic          last_s;
  logic          load_s;
  logic [W-1:0]  load_val_s;
  logic          en_s;
  logic          dir_s;

  // Decode shared conditions and the counter-core controls for this cycle.
  always_comb begin
    start_req_s = start_i & ~abort_i;
    lim_bad_s   = (hi_lim_i <= lo_lim_i) || (n_sweeps_i == NW'(0));
    run_s       = ~abort_i & ~pause_i;
    at_hi_s     = (count_s == hi_q);
    at_lo_s     = (count_s == lo_q);
    last_s      = ((sweeps_done_q + NW'(1)) == n_q);
    load_s      = 1'b0;
    load_val_s  = lo_lim_i;
    en_s        = 1'b0;
    dir_s       = 1'b1;
    case (state_q)
      IDLE: begin
        if (start_req_s && !lim_bad_s) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      UP: begin
        if (run_s) begin
          en_s  = 1'b1;
          dir_s = ~at_hi_s;
        end else begin
          en_s = 1'b0;
        end
      end
      DOWN: begin
        // At lo the final sweep parks the count; otherwise it bounces upward.
        if (run_s) begin
          if (at_lo_s) begin
            en_s  = ~last_s;
            dir_s = 1'b1;
          end else begin
            en_s  = 1'b1;
            dir_s = 1'b0;
          end
        end else begin
          en_s = 1'b0;
        end
      end
      DONE: begin
        en_s = 1'b0;
      end
      default: begin
        en_s = 1'b0;
      end
    endcase
  end

  // Sequencer state and all registered status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      lo_q          <= '0;
      hi_q          <= '0;
      n_q           <= '0;
      sweeps_done_q <= '0;
      up_down_q     <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_req_s) begin
            if (lim_bad_s) begin
              err_q <= 1'b1;
            end else begin
              lo_q          <= lo_lim_i;
              hi_q          <= hi_lim_i;
              n_q           <= n_sweeps_i;
              sweeps_done_q <= '0;
              up_down_q     <= 1'b1;
              busy_q        <= 1'b1;
              state_q       <= UP;
            end
          end
        end
        UP: begin
          if (abort_i) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (!pause_i && at_hi_s) begin
            up_down_q <= 1'b0;
            state_q   <= DOWN;
          end
        end
        DOWN: begin
          if (abort_i) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (!pause_i && at_lo_s) begin
            sweeps_done_q <= sweeps_done_q + NW'(1);
            if (last_s) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              up_down_q <= 1'b1;
              state_q   <= UP;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  sweep_counter_core #(
    .W (W)
  ) u_core (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load_s),
    .load_val_i (load_val_s),
    .en_i       (en_s),
    .up_down_i  (dir_s),
    .count_o    (count_s)
  );

  assign count_o       = count_s;
  assign up_down_o     = up_down_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign sweeps_done_o = sweeps_done_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_sweep_counter_ctrl.sv
// Scoreboard bench: the driver pushes the expected post-edge outputs for every
// cycle it drives; an independent monitor pops and compares one entry per cycle.
module tb_sweep_counter_ctrl;
  import sweep_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       pause;
  logic [3:0] lo_lim;
  logic [3:0] hi_lim;
  logic [3:0] n_sweeps;
  logic [3:0] count;
  logic       up_down;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] sweeps_done;
  logic [1:0] dbg_state;

  typedef struct {
    int         id;
    logic [1:0] st;
    logic [3:0] cnt;
    logic       ud;
    logic       bsy;
    logic       dn;
    logic       er;
    logic [3:0] sw;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  sweep_counter_ctrl #(.W(4), .NW(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .abort_i       (abort),
    .pause_i       (pause),
    .lo_lim_i      (lo_lim),
    .hi_lim_i      (hi_lim),
    .n_sweeps_i    (n_sweeps),
    .count_o       (count),
    .up_down_o     (up_down),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err),
    .sweeps_done_o (sweeps_done),
    .dbg_state_o   (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic cyc(input logic r, input logic s, input logic a, input logic p,
                     input logic [3:0] lo, input logic [3:0] hi, input logic [3:0] n,
                     input logic [1:0] est, input logic [3:0] ecnt, input logic eud,
                     input logic ebsy, input logic edn, input logic eer, input logic [3:0] esw);
    exp_t e;
    @(negedge clk);
    rst = r; start = s; abort = a; pause = p;
    lo_lim = lo; hi_lim = hi; n_sweeps = n;
    e.id = vec_id; e.st = est; e.cnt = ecnt; e.ud = eud;
    e.bsy = ebsy; e.dn = edn; e.er = eer; e.sw = esw;
    exp_q.push_back(e);
    vec_id++;
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #4;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (dbg_state !== e.st || count !== e.cnt || up_down !== e.ud || busy !== e.bsy ||
            done !== e.dn || err !== e.er || sweeps_done !== e.sw) begin
          errors++;
          $display("FAIL vec%0d: got st=%0d cnt=%0d ud=%b busy=%b done=%b err=%b sw=%0d, want st=%0d cnt=%0d ud=%b busy=%b done=%b err=%b sw=%0d",
                   e.id, dbg_state, count, up_down, busy, done, err, sweeps_done,
                   e.st, e.cnt, e.ud, e.bsy, e.dn, e.er, e.sw);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
    lo_lim = 4'd0; hi_lim = 4'd0; n_sweeps = 4'd0;

    // Reset state
    cyc(1'b1,1'b0,1'b0,1'b0, 4'd0,4'd0,4'd0,  ST_IDLE,4'd0,1'b1,1'b0,1'b0,1'b0,4'd0);
    cyc(1'b1,1'b0,1'b0,1'b0, 4'd0,4'd0,4'd0,  ST_IDLE,4'd0,1'b1,1'b0,1'b0,1'b0,4'd0);

    // Single sweep lo=2 hi=4 n=1
    cyc(1'b0,1'b1,1'b0,1'b0, 4'd2,4'd4,4'd1,  ST_UP,  4'd2,1'b1,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd2,4'd4,4'd1,  ST_UP,  4'd3,1'b1,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd2,4'd4,4'd1,  ST_UP,  4'd4,1'b1,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd2,4'd4,4'd1,  ST_DOWN,4'd3,1'b0,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd2,4'd4,4'd1,  ST_DOWN,4'd2,1'b0,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd2,4'd4,4'd1,  ST_DONE,4'd2,1'b0,1'b0,1'b1,1'b0,4'd1);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd2,4'd4,4'd1,  ST_IDLE,4'd2,1'b0,1'b0,1'b0,1'b0,4'd1);

    // Minimal span lo=0 hi=1 n=2
    cyc(1'b0,1'b1,1'b0,1'b0, 4'd0,4'd1,4'd2,  ST_UP,  4'd0,1'b1,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd0,4'd1,4'd2,  ST_UP,  4'd1,1'b1,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd0,4'd1,4'd2,  ST_DOWN,4'd0,1'b0,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd0,4'd1,4'd2,  ST_UP,  4'd1,1'b1,1'b1,1'b0,1'b0,4'd1);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd0,4'd1,4'd2,  ST_DOWN,4'd0,1'b0,1'b1,1'b0,1'b0,4'd1);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd0,4'd1,4'd2,  ST_DONE,4'd0,1'b0,1'b0,1'b1,1'b0,4'd2);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd0,4'd1,4'd2,  ST_IDLE,4'd0,1'b0,1'b0,1'b0,1'b0,4'd2);

    // Top-of-range turnaround lo=13 hi=15 n=1
    cyc(1'b0,1'b1,1'b0,1'b0, 4'd13,4'd15,4'd1, ST_UP,  4'd13,1'b1,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd13,4'd15,4'd1, ST_UP,  4'd14,1'b1,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd13,4'd15,4'd1, ST_UP,  4'd15,1'b1,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd13,4'd15,4'd1, ST_DOWN,4'd14,1'b0,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd13,4'd15,4'd1, ST_DOWN,4'd13,1'b0,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd13,4'd15,4'd1, ST_DONE,4'd13,1'b0,1'b0,1'b1,1'b0,4'd1);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd13,4'd15,4'd1, ST_IDLE,4'd13,1'b0,1'b0,1'b0,1'b0,4'd1);

    // Rejected starts: hi==lo, then n==0; a start alongside abort is simply ignored
    cyc(1'b0,1'b1,1'b0,1'b0, 4'd5,4'd5,4'd1,  ST_IDLE,4'd13,1'b0,1'b0,1'b0,1'b1,4'd1);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd5,4'd5,4'd1,  ST_IDLE,4'd13,1'b0,1'b0,1'b0,1'b0,4'd1);
    cyc(1'b0,1'b1,1'b0,1'b0, 4'd2,4'd4,4'd0,  ST_IDLE,4'd13,1'b0,1'b0,1'b0,1'b1,4'd1);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd2,4'd4,4'd0,  ST_IDLE,4'd13,1'b0,1'b0,1'b0,1'b0,4'd1);
    cyc(1'b0,1'b1,1'b1,1'b0, 4'd2,4'd4,4'd1,  ST_IDLE,4'd13,1'b0,1'b0,1'b0,1'b0,4'd1);

    // Pause at 4 for three cycles, resume, then abort (with pause also high) at 5
    cyc(1'b0,1'b1,1'b0,1'b0, 4'd1,4'd6,4'd1,  ST_UP,  4'd1,1'b1,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd1,4'd6,4'd1,  ST_UP,  4'd2,1'b1,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd1,4'd6,4'd1,  ST_UP,  4'd3,1'b1,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd1,4'd6,4'd1,  ST_UP,  4'd4,1'b1,1'b1,1'b0,1'b0,4'd0);
    for (int i = 0; i < 3; i++)
      cyc(1'b0,1'b0,1'b0,1'b1, 4'd1,4'd6,4'd1, ST_UP, 4'd4,1'b1,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd1,4'd6,4'd1,  ST_UP,  4'd5,1'b1,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd1,4'd6,4'd1,  ST_UP,  4'd6,1'b1,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd1,4'd6,4'd1,  ST_DOWN,4'd5,1'b0,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b0,1'b1,1'b1, 4'd1,4'd6,4'd1,  ST_IDLE,4'd5,1'b0,1'b0,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd1,4'd6,4'd1,  ST_IDLE,4'd5,1'b0,1'b0,1'b0,1'b0,4'd0);

    // Mid-run start re-assert and hi change to 9 are ignored; turn still at latched 4
    cyc(1'b0,1'b1,1'b0,1'b0, 4'd2,4'd4,4'd1,  ST_UP,  4'd2,1'b1,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b1,1'b0,1'b0, 4'd2,4'd9,4'd1,  ST_UP,  4'd3,1'b1,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b1,1'b0,1'b0, 4'd2,4'd9,4'd1,  ST_UP,  4'd4,1'b1,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b1,1'b0,1'b0, 4'd2,4'd9,4'd1,  ST_DOWN,4'd3,1'b0,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b1,1'b0,1'b0, 4'd2,4'd9,4'd1,  ST_DOWN,4'd2,1'b0,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b1,1'b0,1'b0, 4'd2,4'd9,4'd1,  ST_DONE,4'd2,1'b0,1'b0,1'b1,1'b0,4'd1);
    cyc(1'b0,1'b1,1'b0,1'b0, 4'd2,4'd9,4'd1,  ST_IDLE,4'd2,1'b0,1'b0,1'b0,1'b0,4'd1);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd2,4'd9,4'd1,  ST_IDLE,4'd2,1'b0,1'b0,1'b0,1'b0,4'd1);

    // Reset held two cycles mid-sweep
    cyc(1'b0,1'b1,1'b0,1'b0, 4'd0,4'd9,4'd3,  ST_UP,  4'd0,1'b1,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd0,4'd9,4'd3,  ST_UP,  4'd1,1'b1,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd0,4'd9,4'd3,  ST_UP,  4'd2,1'b1,1'b1,1'b0,1'b0,4'd0);
    cyc(1'b1,1'b0,1'b0,1'b0, 4'd0,4'd9,4'd3,  ST_IDLE,4'd0,1'b1,1'b0,1'b0,1'b0,4'd0);
    cyc(1'b1,1'b0,1'b0,1'b0, 4'd0,4'd9,4'd3,  ST_IDLE,4'd0,1'b1,1'b0,1'b0,1'b0,4'd0);
    cyc(1'b0,1'b0,1'b0,1'b0, 4'd0,4'd9,4'd3,  ST_IDLE,4'd0,1'b1,1'b0,1'b0,1'b0,4'd0);

    // Let the monitor drain the queue within a bounded number of cycles
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge clk);
    #6;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
